// File: rtl/dm_pkg.sv
// Shared types and widths for the dm_bank data memory.
package dm_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BYTEEN_W = 4;
  localparam int unsigned WAIT_W   = 4;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } dm_state_e;

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge: enabled lanes take the new word, the rest keep the old word.
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [WORD_W-1:0]   old_word,
  input  logic [WORD_W-1:0]   new_word,
  input  logic [BYTEEN_W-1:0] byteen,
  output logic [WORD_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < BYTEEN_W; i++) begin
      if (byteen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_bank.sv
// Byte-enable data memory slave with wait states, post-reset zero sweep and range check.
// Define DM_TRACE_EN to enable the write-commit trace port; otherwise trace outputs are tied to 0.
module dm_bank
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  dm_state_e                 state, state_next;
  logic [ADDR_WIDTH-1:0]     ptr;
  logic [WAIT_W-1:0]         cnt;
  logic [31:0]               lat_addr;
  logic [BYTEEN_W-1:0]       lat_be;
  logic [WORD_W-1:0]         lat_wdata;

  logic [WORD_W-1:0]         mem [DEPTH];

  logic [31:0]               offset;
  logic                      in_range;
  logic                      is_write;
  logic                      commit;
  logic                      commit_write;
  logic [ADDR_WIDTH-1:0]     idx;
  logic [WORD_W-1:0]         old_word;
  logic [WORD_W-1:0]         merged;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_waddr;
  logic [WORD_W-1:0]         mem_wdata;
  logic                      unused_bits;

  assign offset       = lat_addr - BASE_ADDR;
  assign in_range     = (lat_addr >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign idx          = offset[ADDR_WIDTH+1:2];
  assign is_write     = (lat_be != '0);
  assign old_word     = mem[idx];
  // Every accept passes through WAIT; the edge leaving WAIT is the commit edge,
  // giving a response WAIT_CYCLES+1 edges after the accept.
  assign commit       = (state == S_WAIT) && (cnt == '0);
  assign commit_write = commit && in_range && is_write;

  dm_byte_merge u_merge (
    .old_word (old_word),
    .new_word (lat_wdata),
    .byteen   (lat_be),
    .merged   (merged)
  );

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_CLEAR: if (ptr == '1) state_next = S_IDLE;
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_WAIT;
      end
      S_WAIT:  if (cnt == '0) state_next = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      ptr        <= '0;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_CLEAR) ptr <= ptr + 1'b1;
      if (state == S_IDLE && req_valid) begin
        lat_addr  <= {req_addr[31:2], 2'b00};
        lat_be    <= req_byteen;
        lat_wdata <= req_wdata;
        cnt       <= WAIT_W'(WAIT_CYCLES);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        resp_err   <= !in_range;
        resp_rdata <= !in_range ? '0 : (is_write ? merged : old_word);
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = merged;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = '0;
    end else if (commit_write) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef DM_TRACE_EN
  logic [31:0] lat_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_pc      <= '0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      if (state == S_IDLE && req_valid) lat_pc <= req_pc;
      trace_valid <= commit_write;
      if (commit_write) begin
        trace_pc   <= lat_pc;
        trace_addr <= lat_addr;
        trace_data <= merged;
      end
    end
  end

  assign unused_bits = ^req_addr[1:0];
`else
  assign trace_valid = 1'b0;
  assign trace_pc    = '0;
  assign trace_addr  = '0;
  assign trace_data  = '0;
  assign unused_bits = ^{req_addr[1:0], req_pc};
`endif

endmodule

// File: tb/tb_dm_bank.sv
// Directed bench for dm_bank: instance 0 has no wait states, instance 1 has three; both DEPTH=16.
module tb_dm_bank;

  logic        clk;
  logic        reset;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [31:0] req_addr    [2];
  logic [3:0]  req_byteen  [2];
  logic [31:0] req_wdata   [2];
  logic [31:0] req_pc      [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [31:0] resp_rdata  [2];
  logic        resp_err    [2];
  logic        trace_valid [2];
  logic [31:0] trace_pc    [2];
  logic [31:0] trace_addr  [2];
  logic [31:0] trace_data  [2];

  int vectors;
  int miscompares;

  dm_bank #(.ADDR_WIDTH(4), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_byteen(req_byteen[0]), .req_wdata(req_wdata[0]), .req_pc(req_pc[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .trace_valid(trace_valid[0]), .trace_pc(trace_pc[0]),
    .trace_addr(trace_addr[0]), .trace_data(trace_data[0])
  );

  dm_bank #(.ADDR_WIDTH(4), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0000)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_byteen(req_byteen[1]), .req_wdata(req_wdata[1]), .req_pc(req_pc[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .trace_valid(trace_valid[1]), .trace_pc(trace_pc[1]),
    .trace_addr(trace_addr[1]), .trace_data(trace_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete request/response; entered and left at 1 time unit after a rising edge.
  task automatic xact(input int d, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] pc,
                      output logic [31:0] rd, output logic err, output int lat,
                      output logic tv, output logic [31:0] ta, output logic [31:0] td,
                      output logic [31:0] tp, output logic tv_after, output logic ready_after);
    int n;
    n = 0;
    while (!req_ready[d] && n < 64) begin @(posedge clk); #1; n++; end
    req_valid[d] = 1'b1; req_addr[d] = addr; req_byteen[d] = be;
    req_wdata[d] = wdata; req_pc[d] = pc; resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 64) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata[d]; err = resp_err[d];
    tv = trace_valid[d]; ta = trace_addr[d]; td = trace_data[d]; tp = trace_pc[d];
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    tv_after = trace_valid[d];
    ready_after = req_ready[d];
  endtask

  logic [31:0] rd, ta, td, tp;
  logic        err, tv, tv_after, ready_after;
  int          lat;

  task automatic test_reset;
    int first0, first1;
    reset = 1'b1;
    #3;
    vectors++; if (req_ready[0] !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready got %b want 0", req_ready[0]); end
    vectors++; if (resp_valid[0] !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid got %b want 0", resp_valid[0]); end
    vectors++; if (resp_rdata[0] !== 32'h0) begin miscompares++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata[0]); end
    vectors++; if (resp_err[0] !== 1'b0) begin miscompares++; $display("FAIL rst_resp_err got %b want 0", resp_err[0]); end
    vectors++; if ({trace_valid[0], trace_pc[0], trace_addr[0], trace_data[0]} !== 97'h0) begin
      miscompares++; $display("FAIL rst_trace got %b/%h/%h/%h want all 0", trace_valid[0], trace_pc[0], trace_addr[0], trace_data[0]); end
    @(posedge clk); #1;
    reset = 1'b0;
    first0 = 0; first1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (req_ready[0] && first0 == 0) first0 = i;
      if (req_ready[1] && first1 == 0) first1 = i;
      if (first0 != 0 && first1 != 0) break;
    end
    vectors++; if (first0 != 16) begin miscompares++; $display("FAIL sweep_len_dut0 got %0d edges want 16", first0); end
    vectors++; if (first1 != 16) begin miscompares++; $display("FAIL sweep_len_dut1 got %0d edges want 16", first1); end
  endtask

  task automatic test_zero_sweep;
    for (int i = 0; i < 16; i++) begin
      xact(0, 32'(i * 4), 4'b0000, 32'hFFFF_FFFF, 32'h0, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
      vectors++; if (rd !== 32'h0 || err !== 1'b0) begin
        miscompares++; $display("FAIL zero_word[%0d] got %h err %b want 00000000 err 0", i, rd, err); end
    end
  endtask

  task automatic test_write_read;
    xact(0, 32'h10, 4'b1111, 32'h1234_5678, 32'h0040_0100, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_full_rdata got %h want 12345678", rd); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL wr_full_latency got %0d want 1", lat); end
    xact(0, 32'h10, 4'b0000, 32'h0, 32'h0040_0104, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_full_rdata got %h want 12345678", rd); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL rd_full_latency got %0d want 1", lat); end
    vectors++; if (tv !== 1'b0) begin miscompares++; $display("FAIL rd_no_trace got %b want 0", tv); end
  endtask

  task automatic test_partial;
    xact(0, 32'h12, 4'b0101, 32'hAABB_CCDD, 32'h0040_0200, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h12BB_56DD) begin miscompares++; $display("FAIL partial_rdata got %h want 12BB56DD", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL partial_err got %b want 0", err); end
`ifdef DM_TRACE_EN
    vectors++; if (tv !== 1'b1) begin miscompares++; $display("FAIL partial_trace_valid got %b want 1", tv); end
    vectors++; if (ta !== 32'h10) begin miscompares++; $display("FAIL partial_trace_addr got %h want 00000010", ta); end
    vectors++; if (td !== 32'h12BB_56DD) begin miscompares++; $display("FAIL partial_trace_data got %h want 12BB56DD", td); end
    vectors++; if (tp !== 32'h0040_0200) begin miscompares++; $display("FAIL partial_trace_pc got %h want 00400200", tp); end
    vectors++; if (tv_after !== 1'b0) begin miscompares++; $display("FAIL partial_trace_pulse got %b want 0 next cycle", tv_after); end
`else
    vectors++; if ({tv, ta, td, tp} !== 97'h0) begin miscompares++; $display("FAIL partial_trace_off got %b/%h/%h/%h want all 0", tv, ta, td, tp); end
`endif
    xact(0, 32'h10, 4'b0000, 32'h0, 32'h0040_0204, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h12BB_56DD) begin miscompares++; $display("FAIL partial_readback got %h want 12BB56DD", rd); end
  endtask

  task automatic test_out_of_range;
    xact(0, 32'h40, 4'b1111, 32'hFFFF_FFFF, 32'h0040_0300, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL oob_err got %b want 1", err); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oob_rdata got %h want 00000000", rd); end
    vectors++; if (tv !== 1'b0) begin miscompares++; $display("FAIL oob_no_trace got %b want 0", tv); end
    xact(0, 32'h0, 4'b0000, 32'h0, 32'h0040_0304, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h0 || err !== 1'b0) begin
      miscompares++; $display("FAIL oob_word0_intact got %h err %b want 00000000 err 0", rd, err); end
    xact(0, 32'h3C, 4'b0000, 32'h0, 32'h0040_0308, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL last_word_err got %b want 0", err); end
    xact(0, 32'h43, 4'b0000, 32'h0, 32'h0040_030C, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (err !== 1'b1 || rd !== 32'h0) begin
      miscompares++; $display("FAIL oob_read got %h err %b want 00000000 err 1", rd, err); end
  endtask

  task automatic test_back_to_back;
    xact(0, 32'h20, 4'b1111, 32'hCAFE_F00D, 32'h0040_0400, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (ready_after !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_take got %b want 1", ready_after); end
    xact(0, 32'h20, 4'b0000, 32'h0, 32'h0040_0404, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL b2b_read got %h want CAFEF00D", rd); end
    xact(0, 32'h20, 4'b1000, 32'h5A00_0000, 32'h0040_0408, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    xact(0, 32'h20, 4'b0000, 32'h0, 32'h0040_040C, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h5AFE_F00D) begin miscompares++; $display("FAIL b2b_merge_read got %h want 5AFEF00D", rd); end
  endtask

  task automatic test_wait_hold;
    int n;
    n = 0;
    while (!req_ready[1] && n < 64) begin @(posedge clk); #1; n++; end
    req_valid[1] = 1'b1; req_addr[1] = 32'h08; req_byteen[1] = 4'b1111;
    req_wdata[1] = 32'h1122_3344; req_pc[1] = 32'h0040_0500; resp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    vectors++; if (req_ready[1] !== 1'b0) begin miscompares++; $display("FAIL wait_ready_after_accept got %b want 0", req_ready[1]); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      vectors++; if (resp_valid[1] !== 1'b0) begin miscompares++; $display("FAIL wait_early_resp at N+%0d got %b want 0", k, resp_valid[1]); end
    end
    @(posedge clk); #1;
    vectors++; if (resp_valid[1] !== 1'b1) begin miscompares++; $display("FAIL wait_resp_at_n4 got %b want 1", resp_valid[1]); end
    vectors++; if (resp_rdata[1] !== 32'h1122_3344) begin miscompares++; $display("FAIL wait_rdata got %h want 11223344", resp_rdata[1]); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++; if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== 32'h1122_3344 || req_ready[1] !== 1'b0) begin
        miscompares++; $display("FAIL wait_hold[%0d] got valid %b data %h ready %b want 1 11223344 0",
                                k, resp_valid[1], resp_rdata[1], req_ready[1]); end
    end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    vectors++; if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      miscompares++; $display("FAIL wait_release got valid %b ready %b want 0 1", resp_valid[1], req_ready[1]); end
    xact(1, 32'h08, 4'b0000, 32'h0, 32'h0040_0504, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h1122_3344) begin miscompares++; $display("FAIL wait_readback got %h want 11223344", rd); end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL wait_latency got %0d want 4", lat); end
  endtask

  task automatic test_reset_mid_write;
    int n, first;
    n = 0;
    while (!req_ready[1] && n < 64) begin @(posedge clk); #1; n++; end
    req_valid[1] = 1'b1; req_addr[1] = 32'h04; req_byteen[1] = 4'b1111;
    req_wdata[1] = 32'hDEAD_BEEF; req_pc[1] = 32'h0040_0600; resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    vectors++; if (req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs got ready %b valid %b want 0 0", req_ready[1], resp_valid[1]); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (req_ready[1]) begin first = i; break; end
    end
    vectors++; if (first != 16) begin miscompares++; $display("FAIL midrst_resweep got %0d edges want 16", first); end
    xact(1, 32'h04, 4'b0000, 32'h0, 32'h0040_0604, rd, err, lat, tv, ta, td, tp, tv_after, ready_after);
    vectors++; if (rd !== 32'h0 || err !== 1'b0) begin
      miscompares++; $display("FAIL midrst_write_dropped got %h err %b want 00000000 err 0", rd, err); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; req_byteen[d] = '0;
      req_wdata[d] = '0; req_pc[d] = '0; resp_ready[d] = 1'b0;
    end
    test_reset;
    test_zero_sweep;
    test_write_read;
    test_partial;
    test_out_of_range;
    test_back_to_back;
    test_wait_hold;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
